meas_readout_buffer: RTL

Parametrised measurement readout buffer. It sits between count_prebufer and the SPI command path in main_ctrl, and replaces the fixed 24-bit, 8-deep FIFO plus byte-serialiser pair. It stores DEPTH measurement words in an internal ring and serves them to the SPI side one byte per request, least-significant byte first. It adds an overflow policy, sticky overflow and underrun flags, and frame-abort handling.

---
 rtl/meas_readout_buffer_pkg.sv | 12 +
 rtl/meas_word_ring.sv | 78 +++++++
 rtl/meas_readout_buffer.sv | 107 ++++++++++
 3 files changed

// File: rtl/meas_readout_buffer_pkg.sv
// Shared defaults and helpers for the measurement readout path (prebuffer, readout buffer, SPI control).
package meas_readout_buffer_pkg;

    localparam int         DEF_WORD_BYTES = 3;
    localparam int         DEF_DEPTH      = 8;
    localparam logic [7:0] DEF_EMPTY_FILL = 8'h00;

    function automatic int level_w(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/meas_word_ring.sv
// Register-array word ring with head/tail/level and full-ring write policy; head word read asynchronously.
// Write-while-full either drops the oldest word or discards the new one; a same-cycle pop always makes room.
module meas_word_ring
    import meas_readout_buffer_pkg::*;
#(
    parameter  int W           = 8 * DEF_WORD_BYTES,
    parameter  int DEPTH       = DEF_DEPTH,
    parameter  bit DROP_OLDEST = 1'b1,
    localparam int LW          = level_w(DEPTH),
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic          clk_12mhz,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_dat,
    input  logic          i_pop,
    output logic [W-1:0]  o_head_dat,
    output logic [LW-1:0] o_level,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_ovf_evt
);

    logic [W-1:0]  r_ring [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [LW-1:0] r_level;

    logic w_push;
    logic w_pop;
    logic w_store;
    logic w_drop;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == LW'(DEPTH));

    assign w_push  = i_push && !i_clear;
    assign w_pop   = i_pop && !i_clear && !o_empty;
    // A pop in the same cycle frees a slot, so the overflow policy only applies without one.
    assign w_store   = w_push && (!o_full || w_pop || DROP_OLDEST);
    assign w_drop    = w_push && o_full && !w_pop && DROP_OLDEST;
    assign o_ovf_evt = w_push && o_full && !w_pop;

    assign o_head_dat = r_ring[r_head];
    assign o_level    = r_level;

    always_ff @(posedge clk_12mhz) begin
        if (w_store) begin
            r_ring[r_tail] <= i_push_dat;
        end
    end

    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
        end else begin
            if (w_store) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_pop || w_drop) begin
                r_head <= r_head + AW'(1);
            end
            if (w_store && !w_drop && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_store) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/meas_readout_buffer.sv
// Measurement word buffer served to SPI one byte per request, LSB first; sticky overflow/underrun, frame abort.
// One-cycle request-to-byte latency, back-to-back requests allowed; no backpressure (full-ring writes follow DROP_OLDEST).
module meas_readout_buffer
    import meas_readout_buffer_pkg::*;
#(
    parameter  int         WORD_BYTES  = DEF_WORD_BYTES,
    parameter  int         DEPTH       = DEF_DEPTH,
    parameter  bit         DROP_OLDEST = 1'b1,
    parameter  logic [7:0] EMPTY_FILL  = DEF_EMPTY_FILL,
    localparam int         W           = 8 * WORD_BYTES,
    localparam int         LW          = level_w(DEPTH)
) (
    input  logic          clk_12mhz,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_byte_req,
    input  logic          xfer_done,
    input  logic          level_clear,
    output logic [7:0]    meas_data,
    output logic          byte_valid,
    output logic [LW-1:0] level,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underrun
);

    localparam int             BW       = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BW-1:0]  LAST_IDX = BW'(WORD_BYTES - 1);
    localparam logic [BW-1:0]  NEXT_IDX = (WORD_BYTES > 1) ? BW'(1) : '0;

    logic [WORD_BYTES-1:0][7:0] r_hold;
    logic [BW-1:0]              r_byte_idx;
    logic [7:0]                 r_meas_data;
    logic                       r_byte_valid;
    logic                       r_overflow;
    logic                       r_underrun;

    logic [W-1:0] w_head_dat;
    logic         w_fetch;
    logic         w_ovf_evt;

    assign w_fetch = rd_byte_req && !level_clear && (r_byte_idx == '0);

    meas_word_ring #(
        .W           (W),
        .DEPTH       (DEPTH),
        .DROP_OLDEST (DROP_OLDEST)
    ) u_ring (
        .clk_12mhz  (clk_12mhz),
        .rst_n      (rst_n),
        .i_clear    (level_clear),
        .i_push     (wr_en),
        .i_push_dat (wr_data),
        .i_pop      (w_fetch),
        .o_head_dat (w_head_dat),
        .o_level    (level),
        .o_empty    (empty),
        .o_full     (full),
        .o_ovf_evt  (w_ovf_evt)
    );

    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_hold       <= '0;
            r_byte_idx   <= '0;
            r_meas_data  <= 8'h00;
            r_byte_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underrun   <= 1'b0;
        end else if (level_clear) begin
            r_byte_idx   <= '0;
            r_byte_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_byte_valid <= rd_byte_req;
            if (w_fetch) begin
                if (!empty) begin
                    r_hold      <= w_head_dat;
                    r_meas_data <= w_head_dat[7:0];
                    r_byte_idx  <= NEXT_IDX;
                end else begin
                    r_meas_data <= EMPTY_FILL;
                    r_underrun  <= 1'b1;
                end
            end else if (rd_byte_req) begin
                r_meas_data <= r_hold[r_byte_idx];
                r_byte_idx  <= (r_byte_idx == LAST_IDX) ? '0 : r_byte_idx + BW'(1);
            end
            // Frame end wins over the index advance: the rest of the word is abandoned.
            if (xfer_done) begin
                r_byte_idx <= '0;
            end
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign meas_data  = r_meas_data;
    assign byte_valid = r_byte_valid;
    assign overflow   = r_overflow;
    assign underrun   = r_underrun;

endmodule
